// File: rtl/palette_scheduler.sv
// palette_scheduler: 4-layer priority pixel compositor with a 4x16x24 palette, boot-time default fill and config writes
module palette_scheduler (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_valid,
   input  logic [3:0]  layer_en,
   input  logic [15:0] layer_idx,
   input  logic [7:0]  layer_bank,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [1:0]  cfg_bank,
   input  logic [3:0]  cfg_addr,
   input  logic [23:0] cfg_rgb,
   output logic [7:0]  red_out,
   output logic [7:0]  green_out,
   output logic [7:0]  blue_out,
   output logic        out_valid,
   output logic [2:0]  out_layer,
   output logic        init_done
);
   typedef enum logic {INIT, RUN} state_t;
   localparam logic [23:0] DEFAULTS [16] = '{
      24'hFFDFCF, 24'h2D1E10, 24'h420000, 24'h570000,
      24'hE4312F, 24'hFF7B68, 24'hA96F3F, 24'hD9D36F,
      24'hCFB4B5, 24'hA11F28, 24'hFE06FF, 24'h734B2A,
      24'h1C4D6C, 24'h2871A2, 24'h000057, 24'hFE06FF
   };
   state_t      state;
   logic [5:0]  init_cnt;
   logic [23:0] palette [64];
   logic        s1_valid;
   logic        s1_hit;
   logic [5:0]  s1_addr;
   logic [1:0]  s1_layer;
   logic [3:0]  qual;
   logic [1:0]  win;
   logic        we;
   logic [5:0]  wa;
   logic [23:0] wd;
   // layer arbitration and shared write-port steering (INIT fill owns the port until RUN)
   always_comb begin
      for (int i = 0; i < 4; i++) qual[i] = layer_en[i] && layer_idx[4*i +: 4] != 4'hA;
      win = qual[0] ? 2'd0 : qual[1] ? 2'd1 : qual[2] ? 2'd2 : 2'd3;
      cfg_ready = state == RUN && !pix_valid && !reset;
      we = !reset && (state == INIT || (cfg_valid && cfg_ready));
      wa = state == INIT ? init_cnt : {cfg_bank, cfg_addr};
      wd = state == INIT ? DEFAULTS[init_cnt[3:0]] : cfg_rgb;
   end
   // INIT walks all 64 entries once, then RUN until reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= INIT;
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else if (state == INIT) begin
         init_cnt <= init_cnt + 6'd1;
         if (init_cnt == 6'd63) begin
            state     <= RUN;
            init_done <= 1'b1;
         end
      end
   end
   // palette write port; the read happens in the stage-2 register so same-edge writes read old data
   always_ff @(posedge clk) begin
      if (we) palette[wa] <= wd;
   end
   // stage 1 latches the winning layer, stage 2 reads the palette and holds outputs when idle
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_hit    <= 1'b0;
         s1_addr   <= '0;
         s1_layer  <= '0;
         out_valid <= 1'b0;
         red_out   <= '0;
         green_out <= '0;
         blue_out  <= '0;
         out_layer <= '0;
      end else begin
         s1_valid  <= pix_valid;
         out_valid <= s1_valid;
         if (pix_valid) begin
            s1_hit   <= |qual;
            s1_addr  <= {layer_bank[{win, 1'b0} +: 2], layer_idx[{win, 2'b00} +: 4]};
            s1_layer <= win;
         end
         if (s1_valid) begin
            {red_out, green_out, blue_out} <= s1_hit ? palette[s1_addr] : 24'h000000;
            out_layer <= s1_hit ? {1'b0, s1_layer} : 3'd4;
         end
      end
   end
endmodule

// File: tb/tb_palette_scheduler.sv
// tb_palette_scheduler: scoreboard bench for palette_scheduler
module tb_palette_scheduler;
   localparam logic [23:0] DEF [16] = '{
      24'hFFDFCF, 24'h2D1E10, 24'h420000, 24'h570000,
      24'hE4312F, 24'hFF7B68, 24'hA96F3F, 24'hD9D36F,
      24'hCFB4B5, 24'hA11F28, 24'hFE06FF, 24'h734B2A,
      24'h1C4D6C, 24'h2871A2, 24'h000057, 24'hFE06FF
   };
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_valid = 1'b0;
   logic [3:0]  layer_en = '0;
   logic [15:0] layer_idx = '0;
   logic [7:0]  layer_bank = '0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [1:0]  cfg_bank = '0;
   logic [3:0]  cfg_addr = '0;
   logic [23:0] cfg_rgb = '0;
   logic [7:0]  red_out, green_out, blue_out;
   logic        out_valid;
   logic [2:0]  out_layer;
   logic        init_done;
   logic [26:0] exp_q [$];
   logic [26:0] last_exp = '0;
   int          checks = 0;
   int          errors = 0;
   int          run_len = 0;
   int          max_run = 0;

   palette_scheduler dut (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .layer_en(layer_en),
      .layer_idx(layer_idx), .layer_bank(layer_bank), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_bank(cfg_bank), .cfg_addr(cfg_addr), .cfg_rgb(cfg_rgb),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .out_valid(out_valid), .out_layer(out_layer), .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
         if (exp_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
         else chk("pixel_out", {5'd0, red_out, green_out, blue_out, out_layer}, {5'd0, exp_q.pop_front()});
      end else run_len = 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pix_valid = 1'b0;
      tick();
   endtask

   task automatic pix(input logic [3:0] en, input logic [15:0] idx, input logic [7:0] bank,
                      input logic [23:0] rgb, input logic [2:0] lay);
      pix_valid = 1'b1;
      layer_en = en;
      layer_idx = idx;
      layer_bank = bank;
      exp_q.push_back({rgb, lay});
      last_exp = {rgb, lay};
      tick();
   endtask

   task automatic drain();
      repeat (4) idle();
      chk("drain_queue_empty", exp_q.size(), 32'd0);
      chk("hold_outputs", {5'd0, red_out, green_out, blue_out, out_layer}, {5'd0, last_exp});
   endtask

   task automatic init_walk();
      for (int k = 1; k <= 64; k++) begin
         tick();
         chk("init_done_walk", init_done, k == 64);
         chk("cfg_ready_walk", cfg_ready, k == 64);
      end
   endtask

   task automatic cfg_write(input logic [1:0] b, input logic [3:0] a, input logic [23:0] rgb);
      cfg_valid = 1'b1;
      cfg_bank = b;
      cfg_addr = a;
      cfg_rgb = rgb;
      #1 chk("cfg_ready_accept", cfg_ready, 1'b1);
      tick();
      cfg_valid = 1'b0;
   endtask

   initial begin
      repeat (3) idle();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_rgb", {red_out, green_out, blue_out}, 24'h0);
      chk("rst_out_layer", out_layer, 3'd0);
      chk("rst_init_done", init_done, 1'b0);
      chk("rst_cfg_ready", cfg_ready, 1'b0);
      reset = 1'b0;
      init_walk();
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < 16; a++)
            if (a == 10) pix(4'b0001, {12'h0, 4'(a)}, {6'h0, 2'(b)}, 24'h0, 3'd4);
            else pix(4'b0001, {12'h0, 4'(a)}, {6'h0, 2'(b)}, DEF[a], 3'd0);
      drain();
      pix(4'b0011, 16'h004A, 8'h08, 24'hE4312F, 3'd1);
      pix(4'b1111, 16'hAAAA, 8'hFF, 24'h000000, 3'd4);
      pix(4'b0000, 16'h1234, 8'h00, 24'h000000, 3'd4);
      pix(4'b1110, 16'h3210, 8'h00, 24'h2D1E10, 3'd1);
      pix(4'b1000, 16'hC000, 8'hC0, 24'h1C4D6C, 3'd3);
      pix(4'b0101, 16'h0E0A, 8'h30, 24'h000057, 3'd2);
      drain();
      cfg_write(2'd3, 4'd4, 24'h123456);
      pix(4'b0001, 16'h0004, 8'h03, 24'h123456, 3'd0);
      pix(4'b0001, 16'h0004, 8'h00, 24'hE4312F, 3'd0);
      pix(4'b0001, 16'h0005, 8'h01, 24'hFF7B68, 3'd0);
      pix_valid = 1'b0;
      cfg_write(2'd1, 4'd5, 24'hABCDEF);
      pix(4'b0001, 16'h0005, 8'h01, 24'hABCDEF, 3'd0);
      drain();
      max_run = 0;
      cfg_valid = 1'b1;
      cfg_bank = 2'd2;
      cfg_addr = 4'd7;
      cfg_rgb = 24'h0F0F0F;
      for (int i = 0; i < 10; i++) begin
         pix_valid = 1'b1;
         layer_en = 4'b0001;
         layer_idx = {12'h0, 4'(i)};
         layer_bank = (i == 7) ? 8'h02 : 8'h00;
         exp_q.push_back({DEF[i], 3'd0});
         last_exp = {DEF[i], 3'd0};
         #1 chk("burst_cfg_ready_low", cfg_ready, 1'b0);
         tick();
      end
      pix_valid = 1'b0;
      #1 chk("burst_cfg_ready_high", cfg_ready, 1'b1);
      tick();
      cfg_valid = 1'b0;
      pix(4'b0001, 16'h0007, 8'h02, 24'h0F0F0F, 3'd0);
      drain();
      chk("burst_no_bubbles", max_run >= 10, 1'b1);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      repeat (30) idle();
      chk("mid_init_done_low", init_done, 1'b0);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      init_walk();
      repeat (2) idle();
      pix_valid = 1'b1;
      layer_en = 4'b0001;
      layer_idx = 16'h0000;
      layer_bank = 8'h00;
      tick();
      pix_valid = 1'b0;
      reset = 1'b1;
      cfg_valid = 1'b1;
      cfg_bank = 2'd0;
      cfg_addr = 4'd0;
      cfg_rgb = 24'hDEAD00;
      #1 chk("rst_with_cfg_ready", cfg_ready, 1'b0);
      tick();
      reset = 1'b0;
      cfg_valid = 1'b0;
      init_walk();
      chk("queue_after_flush", exp_q.size(), 32'd0);
      pix(4'b0001, 16'h0004, 8'h03, 24'hE4312F, 3'd0);
      pix(4'b0001, 16'h0005, 8'h01, 24'hFF7B68, 3'd0);
      pix(4'b0001, 16'h0007, 8'h02, 24'hD9D36F, 3'd0);
      pix(4'b0001, 16'h0000, 8'h00, 24'hFFDFCF, 3'd0);
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/palette_scheduler.md
PALETTE_SCHEDULER -- requirements
Module: palette_scheduler

Interface
REQ-001 The block SHALL use one clock and synchronous, active-high reset:
- Clk  in  1  system/pixel clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
REQ-002 The block SHALL have these pixel request ports:
- pix_valid  in  1  pixel request strobe, one request per cycle
- layer_en  in  4  per-layer enable; layer 0 is highest priority
- layer_idx  in  16  4-bit palette index per layer; layer i uses bits [4i+3:4i]
- layer_bank  in  8  2-bit bank select per layer; layer i uses bits [2i+1:2i]
REQ-003 The block SHALL have these configuration ports:
- cfg_valid  in  1  palette write request
- cfg_ready  out  1  write accepted when cfg_valid and cfg_ready are both high
- cfg_bank  in  2  target bank
- cfg_addr  in  4  target entry
- cfg_rgb  in  24  {R,G,B} write data
REQ-004 The block SHALL have these output ports:
- red_out  out  8  red component
- green_out  out  8  green component
- blue_out  out  8  blue component
- out_valid  out  1  RGB outputs valid
- out_layer  out  3  winning layer number 0-3; value 4 means no layer won
- init_done  out  1  high once the palette is initialised

Function
REQ-005 Palette storage SHALL be 4 banks x 16 entries x 24 bits, with a registered read port and one write port.
REQ-006 The FSM SHALL have states INIT and RUN:
- Reset always enters INIT.
- INIT advances to RUN after 64 cycles.
- RUN remains in RUN until Reset.
REQ-007 INIT SHALL write one entry per cycle using a 6-bit counter {bank,addr}, counting 0..63.
REQ-008 Each INIT write SHALL load the default value for its addr, identical in every bank:
- 0 FFDFCF, 1 2D1E10, 2 420000, 3 570000
- 4 E4312F, 5 FF7B68, 6 A96F3F, 7 D9D36F
- 8 CFB4B5, 9 A11F28, A FE06FF, B 734B2A
- C 1C4D6C, D 2871A2, E 000057, F FE06FF
REQ-009 init_done SHALL be 0 in INIT and 1 in RUN; it SHALL rise on the cycle after the write of entry 63.
REQ-010 Index 4'hA SHALL be the transparency key in every bank, regardless of the stored colour.
REQ-011 Stage 1 (cycle N+1 after pix_valid at cycle N) SHALL register the winning layer:
- winner = lowest-numbered layer i with layer_en[i]=1 and layer_idx[i] != 4'hA
- register that layer's bank, index and number
- if no layer qualifies, register "none"
REQ-012 Stage 2 (cycle N+2) SHALL present the outputs:
- winner exists: palette[bank][idx] on red_out/green_out/blue_out, winner number on out_layer
- no winner: 000000 on RGB, 3'd4 on out_layer
- out_valid = 1
REQ-013 Total latency SHALL be exactly 2 cycles; back-to-back pix_valid SHALL give back-to-back out_valid with no bubbles.
REQ-014 pix_valid in INIT SHALL be processed as normal through the pipeline.
REQ-015 The palette read in INIT SHALL return the current array contents, which may be partly initialised.
REQ-016 cfg_ready SHALL equal (state==RUN) AND NOT pix_valid, combinationally.
REQ-017 An accepted write SHALL update palette[cfg_bank][cfg_addr] at that clock edge.
REQ-018 A write accepted in the same cycle that stage 2 reads the same entry SHALL return the pre-write value; the new value SHALL be visible from the next read.
REQ-019 cfg_valid without cfg_ready SHALL have no effect; the requester SHALL hold the request until accepted.
REQ-020 When out_valid is 0, the RGB outputs and out_layer SHALL hold their last values.

Reset
REQ-021 On Reset the block SHALL:
- set red_out = green_out = blue_out = 0, out_layer = 0
- clear out_valid, init_done and both pipeline valid bits
- clear the INIT counter and force cfg_ready to 0
REQ-022 Reset during RUN or mid-INIT SHALL:
- discard in-flight pixels
- restart INIT from entry 0
- overwrite all configured colours with the defaults
REQ-023 Reset asserted together with cfg_valid SHALL ignore the write.

Verification
REQ-024 Reset then idle -> init_done = 0 for cycles 1..64 and 1 from cycle 65; every bank/addr reads its default; cfg_ready = 1 only after init_done = 1.
REQ-025 RUN, layer_en=4'b0011, idx0=A, idx1=4, bank1=2 -> two cycles later out_valid = 1, RGB = E4312F, out_layer = 1.
REQ-026 RUN, all layers enabled with idx = A -> RGB = 000000, out_layer = 4; with layer_en = 0 -> same result.
REQ-027 RUN, write bank3 addr4 = 123456 (accepted), then layer0 en, bank3, idx4 -> RGB = 123456; bank0 addr4 still reads E4312F.
REQ-028 Ten consecutive pix_valid cycles with cfg_valid held -> cfg_ready = 0 throughout, ten consecutive out_valid cycles; write accepted in the first cycle pix_valid is low.
REQ-029 Reset asserted at INIT count 30, then again 3 cycles into RUN with a pixel in flight -> no out_valid for the in-flight pixel; init_done low for a full 64 cycles; configured entries return to their defaults.
